usb_rx_unstuff_deser: RTL and testbench
=======================================

// Module: usb_rx_unstuff_deser
// PURPOSE
//  Downstream consumer of nrzi_decoder. Hunts for SYNC in the decoded bit stream, strips stuffed bits
//  (a 0 after six consecutive 1s), and assembles LSB-first bytes for the packet layer.
//  Packet end comes from the line-state SE0 detector and is reported with an integrity flag.
// PARAMETERS
//  SYNC_PATTERN  8'h80  shift-register value on SYNC completion (bits 0,0,0,0,0,0,0,1 shifted in at MSB)
//  MAX_ONES      6      run of consecutive 1s after which the next bit is a stuffed bit
// PORTS
//  clk             in   1  system clock
//  nRST            in   1  asynchronous active-low reset
//  pulse           in   1  DPLL bit-sample strobe; decoded_bit is valid in this cycle
//  start_decoding  in   1  receive window open; low forces IDLE
//  decoded_bit     in   1  NRZI-decoded bit from nrzi_decoder
//  eop             in   1  SE0/EOP detected (level), from line-state logic
//  rx_byte         out  8  assembled byte, held until the next byte_valid
//  byte_valid      out  1  1-cycle strobe; rx_byte is new
//  rx_active       out  1  high from SYNC match until packet end or abort
//  pkt_end         out  1  1-cycle strobe at packet end
//  pkt_err         out  1  qualifies pkt_end: partial byte or stuff error; held until next SYNC
// BEHAVIOUR
//  - Reset: state=IDLE; shift register, bit_cnt, ones_cnt = 0; all outputs 0.
//  - Registered outputs: byte_valid/pkt_end assert the cycle after the causing pulse/eop edge.
//  - IDLE: start_decoding=1 -> HUNT; shift register cleared.
//  - HUNT: on pulse, sr <= {decoded_bit, sr[7:1]}. If the new sr == SYNC_PATTERN: go DATA,
//    rx_active=1, bit_cnt=0, ones_cnt=1 (the final SYNC 1 counts toward the stuff run), pkt_err=0.
//    eop in HUNT is ignored.
//  - DATA, on pulse:
//    - ones_cnt==MAX_ONES: the bit is stuffed and is not shifted.
//      - bit 0: ones_cnt=0.
//      - bit 1: see STUFF_ERR_EN.
//    - Otherwise: shift into sr; ones_cnt = bit ? ones_cnt+1 : 0; bit_cnt++.
//      - bit_cnt reaching 8: rx_byte <= sr, byte_valid=1, bit_cnt=0.
//  - DATA, eop rising (registered edge detect) -> END for 1 cycle:
//    - pkt_end=1; pkt_err |= (bit_cnt!=0); rx_active=0.
//    - END -> HUNT if start_decoding=1, else IDLE.
//  - eop and pulse in the same cycle: eop wins; that bit is discarded.
//  - Byte completion and eop in the same cycle: eop wins; the final byte is still emitted in the same
//    cycle as pkt_end.
//  - start_decoding=0 in any state: next cycle IDLE, rx_active=0, no pkt_end. rx_byte holds its value.
//  - bit_cnt is 3 bits plus a wrap flag. ones_cnt saturates at MAX_ONES.
// CONFIGURATION
//  STUFF_ERR_EN defined: a 1 where a stuffed 0 is expected -> pkt_err=1, pkt_end=1, rx_active=0,
//    state -> HUNT (packet aborted). Bytes already emitted stand.
//  STUFF_ERR_EN undefined: that bit is dropped silently, ones_cnt=0, reception continues.
// TESTING
//  1. Reset mid-DATA (nRST low 1 cycle) -> all outputs 0, state IDLE, next SYNC still detected.
//  2. SYNC (0000_0001) then 0xA5 LSB-first, eop -> byte_valid once with rx_byte=8'hA5; pkt_end=1,
//     pkt_err=0; rx_active high 1 cycle after SYNC match until END.
//  3. SYNC then 0xFF 0xFF (stuffed 0 after 5 data 1s, SYNC 1 included, then every 6) -> two
//     byte_valid, both 8'hFF; stuffed bits absent from output.
//  4. SYNC, 0x3C, then 3 more bits, eop -> one byte 8'h3C; pkt_end=1 with pkt_err=1.
//  5. SYNC, seven consecutive 1s: with STUFF_ERR_EN -> pkt_end=1, pkt_err=1, rx_active=0;
//     without -> no pkt_end, following byte 0x12 decodes correctly.
//  6. start_decoding dropped after 4 data bits -> IDLE next cycle, no byte_valid, no pkt_end;
//     pulse+eop same cycle -> bit dropped, pkt_end only.

Source files
------------

// File: rtl/usb_rx_unstuff_deser.sv
// USB RX SYNC hunt, bit unstuffing and LSB-first byte assembly; optional STUFF_ERR_EN aborts on stuff error.
// Latency: byte_valid/pkt_end one cycle after the causing pulse/eop edge.
// Backpressure: none; consumer must accept every byte_valid strobe.
module usb_rx_unstuff_deser #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         MAX_ONES     = 6
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       pulse,
    input  logic       start_decoding,
    input  logic       decoded_bit,
    input  logic       eop,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_active,
    output logic       pkt_end,
    output logic       pkt_err
);

    localparam int OW = $clog2(MAX_ONES + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(MAX_ONES);

    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_DATA, ST_END} state_t;

    state_t        state, state_nxt;
    logic [7:0]    sr, sr_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [OW-1:0] ones_cnt, ones_nxt;
    logic          eop_q;
    logic [7:0]    rx_byte_nxt;
    logic          byte_valid_nxt, rx_active_nxt, pkt_end_nxt, pkt_err_nxt;

    logic [7:0] shifted;
    logic [3:0] bit_cnt_inc;
    logic       eop_rise;
    logic       stuff_slot;

    assign shifted     = {decoded_bit, sr[7:1]};
    assign bit_cnt_inc = bit_cnt + 4'd1;
    assign eop_rise    = eop & ~eop_q;
    assign stuff_slot  = (ones_cnt == ONES_MAX);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            eop_q      <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            rx_active  <= 1'b0;
            pkt_end    <= 1'b0;
            pkt_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            ones_cnt   <= ones_nxt;
            eop_q      <= eop;
            rx_byte    <= rx_byte_nxt;
            byte_valid <= byte_valid_nxt;
            rx_active  <= rx_active_nxt;
            pkt_end    <= pkt_end_nxt;
            pkt_err    <= pkt_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        bit_cnt_nxt    = bit_cnt;
        ones_nxt       = ones_cnt;
        rx_byte_nxt    = rx_byte;
        byte_valid_nxt = 1'b0;
        rx_active_nxt  = rx_active;
        pkt_end_nxt    = 1'b0;
        pkt_err_nxt    = pkt_err;

        if (!start_decoding) begin
            state_nxt     = ST_IDLE;
            rx_active_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_HUNT;
                    sr_nxt    = '0;
                end
                ST_HUNT: begin
                    if (pulse) begin
                        sr_nxt = shifted;
                        if (shifted == SYNC_PATTERN) begin
                            state_nxt     = ST_DATA;
                            rx_active_nxt = 1'b1;
                            bit_cnt_nxt   = '0;
                            ones_nxt      = OW'(1);
                            pkt_err_nxt   = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (eop_rise) begin
                        state_nxt     = ST_END;
                        pkt_end_nxt   = 1'b1;
                        rx_active_nxt = 1'b0;
                        // A coincident pulse survives only if it completes the final byte.
                        if (pulse && !stuff_slot && bit_cnt_inc[3]) begin
                            rx_byte_nxt    = shifted;
                            byte_valid_nxt = 1'b1;
                            bit_cnt_nxt    = '0;
                        end else begin
                            pkt_err_nxt = pkt_err | (bit_cnt != 4'd0);
                        end
                    end else if (pulse) begin
                        if (stuff_slot) begin
                            ones_nxt = '0;
`ifdef STUFF_ERR_EN
                            if (decoded_bit) begin
                                state_nxt     = ST_HUNT;
                                pkt_err_nxt   = 1'b1;
                                pkt_end_nxt   = 1'b1;
                                rx_active_nxt = 1'b0;
                            end
`endif
                        end else begin
                            sr_nxt   = shifted;
                            ones_nxt = decoded_bit ? ones_cnt + OW'(1) : '0;
                            if (bit_cnt_inc[3]) begin
                                rx_byte_nxt    = shifted;
                                byte_valid_nxt = 1'b1;
                                bit_cnt_nxt    = '0;
                            end else begin
                                bit_cnt_nxt = bit_cnt_inc;
                            end
                        end
                    end
                end
                ST_END: begin
                    state_nxt = ST_HUNT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_unstuff_deser.sv
// Randomized packet-level bench: payload bits are stuffed by a reference encoder and the
// received bytes / end flags are compared against the payload regrouped into LSB-first bytes.
module tb_usb_rx_unstuff_deser;

    logic       clk = 1'b0;
    logic       nRST;
    logic       pulse;
    logic       start_decoding;
    logic       decoded_bit;
    logic       eop;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_active;
    logic       pkt_end;
    logic       pkt_err;

    usb_rx_unstuff_deser dut (
        .clk            (clk),
        .nRST           (nRST),
        .pulse          (pulse),
        .start_decoding (start_decoding),
        .decoded_bit    (decoded_bit),
        .eop            (eop),
        .rx_byte        (rx_byte),
        .byte_valid     (byte_valid),
        .rx_active      (rx_active),
        .pkt_end        (pkt_end),
        .pkt_err        (pkt_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         data_q[$];
    bit         exp_q[$];
    logic [7:0] got_bytes[$];
    logic       got_err[$];

    always @(negedge clk) begin
        if (nRST) begin
            if (byte_valid) got_bytes.push_back(rx_byte);
            if (pkt_end)    got_err.push_back(pkt_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_raw(input bit b);
        pulse       = 1'b1;
        decoded_bit = b;
        tick(1);
        pulse       = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_raw(1'b0);
        send_raw(1'b1);
    endtask

    // Reference encoder: a 0 is inserted after every run of six line 1s.
    task automatic send_stuffed(input int run0);
        int run = run0;
        foreach (data_q[i]) begin
            send_raw(data_q[i]);
            exp_q.push_back(data_q[i]);
            run = data_q[i] ? run + 1 : 0;
            if (run == 6) begin
                send_raw(1'b0);
                run = 0;
            end
        end
        data_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) data_q.push_back(v[i]);
    endtask

    task automatic begin_pkt();
        data_q.delete();
        exp_q.delete();
        got_bytes.delete();
        got_err.delete();
    endtask

    task automatic do_eop();
        tick(2);
        eop = 1'b1;
        tick(2);
        eop = 1'b0;
        tick(4);
    endtask

    task automatic check_pkt(input string tag, input int exp_end, input logic exp_err);
        int         nb;
        logic [7:0] b;
        nb = exp_q.size() / 8;
        check_eq({tag, ".nbytes"}, got_bytes.size(), nb);
        for (int k = 0; k < nb && k < got_bytes.size(); k++) begin
            for (int j = 0; j < 8; j++) b[j] = exp_q[8*k + j];
            check_eq($sformatf("%s.byte%0d", tag, k), got_bytes[k], b);
        end
        check_eq({tag, ".nend"}, got_err.size(), exp_end);
        if (exp_end > 0 && got_err.size() > 0)
            check_eq({tag, ".err"}, got_err[0], exp_err);
    endtask

    initial begin
        int len;
        nRST = 1'b0; pulse = 1'b0; start_decoding = 1'b0; decoded_bit = 1'b0; eop = 1'b0;
        tick(3);
        check_eq("reset_outs", {rx_byte, byte_valid, rx_active, pkt_end, pkt_err}, 12'h0);
        nRST = 1'b1;
        start_decoding = 1'b1;
        tick(3);

        // Reset in the middle of a packet
        begin_pkt();
        send_sync();
        for (int i = 0; i < 4; i++) data_q.push_back(1'b1);
        send_stuffed(1);
        check_eq("mid_active", rx_active, 1'b1);
        nRST = 1'b0;
        #1;
        check_eq("mid_reset_outs", {rx_byte, byte_valid, rx_active, pkt_end, pkt_err}, 12'h0);
        tick(1);
        nRST = 1'b1;
        tick(3);

        // SYNC + 0xA5
        begin_pkt();
        send_sync();
        check_eq("a5_active_after_sync", rx_active, 1'b1);
        push_byte(8'hA5);
        send_stuffed(1);
        do_eop();
        check_eq("a5_active_after_end", rx_active, 1'b0);
        check_pkt("a5", 1, 1'b0);

        // 0xFF 0xFF exercises stuffing including the SYNC 1
        begin_pkt();
        send_sync();
        push_byte(8'hFF);
        push_byte(8'hFF);
        send_stuffed(1);
        do_eop();
        check_pkt("ffff", 1, 1'b0);

        // 0x3C plus a 3-bit tail gives a partial-byte error
        begin_pkt();
        send_sync();
        push_byte(8'h3C);
        data_q.push_back(1'b1); data_q.push_back(1'b0); data_q.push_back(1'b1);
        send_stuffed(1);
        do_eop();
        check_pkt("3c_partial", 1, 1'b1);

        // Seven consecutive 1s after SYNC: the sixth is a 1 in the stuff slot
        begin_pkt();
        send_sync();
        for (int i = 0; i < 7; i++) send_raw(1'b1);
`ifdef STUFF_ERR_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
        check_eq("stufferr_active", rx_active, 1'b0);
        do_eop();
        check_pkt("stufferr", 1, 1'b1);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
        data_q.push_back(1'b0); data_q.push_back(1'b0);
        push_byte(8'h12);
        send_stuffed(0);
        check_eq("stuffdrop_active", rx_active, 1'b1);
        do_eop();
        check_pkt("stuffdrop", 1, 1'b0);
`endif

        // start_decoding dropped mid-packet
        begin_pkt();
        send_sync();
        for (int i = 0; i < 4; i++) data_q.push_back(1'b0);
        send_stuffed(1);
        start_decoding = 1'b0;
        tick(1);
        check_eq("drop_active", rx_active, 1'b0);
        start_decoding = 1'b1;
        tick(2);
        do_eop();
        exp_q.delete();
        check_pkt("drop", 0, 1'b0);

        // pulse and eop in the same cycle: the bit is discarded
        begin_pkt();
        send_sync();
        push_byte(8'h5A);
        send_stuffed(1);
        tick(1);
        pulse = 1'b1; decoded_bit = 1'b1; eop = 1'b1;
        tick(1);
        pulse = 1'b0;
        tick(2);
        eop = 1'b0;
        tick(4);
        check_pkt("pulse_eop", 1, 1'b0);

        // Randomized packets, 1s biased to exercise stuffing
        for (int p = 0; p < 12; p++) begin
            begin_pkt();
            for (int i = 0; i < $urandom_range(0, 3); i++) send_raw(1'b0);
            send_sync();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) data_q.push_back($urandom_range(0, 3) != 0);
            send_stuffed(1);
            do_eop();
            check_pkt($sformatf("rand%0d", p), 1, (len % 8) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
